// File: rtl/l2_ahb_output_arb.sv
// rtl/l2_ahb_output_arb.sv - round-robin address/data phase arbiter for one bus-matrix slave port
module l2_ahb_output_arb #(
  parameter int NUM_MST = 3,
  parameter int MID_W   = 2
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic [NUM_MST-1:0] req_in,
  input  logic [NUM_MST-1:0] held_tran,
  input  logic [NUM_MST-1:0] mastlock,
  input  logic               HREADYM,
  output logic [NUM_MST-1:0] addr_sel,
  output logic [NUM_MST-1:0] data_sel,
  output logic               addr_valid,
  output logic               no_port,
  output logic [MID_W-1:0]   HMASTER,
  output logic               HMASTLOCKM
);

  logic [MID_W-1:0]   own_id_q, own_id_d;
  logic               own_valid_q, own_valid_d;
  logic [MID_W-1:0]   ptr_q, ptr_d;
  logic [NUM_MST-1:0] data_sel_q, data_sel_d;

  logic               hold;
  logic               win_found;
  logic [MID_W-1:0]   win_id;
  logic [MID_W:0]     cand;

  assign hold = own_valid_q & (held_tran[own_id_q] | mastlock[own_id_q]);

  // Scan from farthest to nearest so the candidate just after ptr is written last and wins.
  // The extra bit in cand lets the wrap be a compare-and-subtract for any NUM_MST.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = NUM_MST; k >= 1; k--) begin
      cand = {1'b0, ptr_q} + (MID_W+1)'(k);
      if (cand >= (MID_W+1)'(NUM_MST)) begin
        cand = cand - (MID_W+1)'(NUM_MST);
      end
      if (req_in[cand[MID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[MID_W-1:0];
      end
    end
  end

  always_comb begin
    addr_sel = '0;
    if (own_valid_q) begin
      addr_sel[own_id_q] = 1'b1;
    end
  end

  always_comb begin
    own_id_d    = own_id_q;
    own_valid_d = own_valid_q;
    ptr_d       = ptr_q;
    data_sel_d  = data_sel_q;
    if (HREADYM) begin
      data_sel_d = addr_sel;
      if (!hold) begin
        if (win_found) begin
          own_id_d    = win_id;
          own_valid_d = 1'b1;
          ptr_d       = win_id;
        end else begin
          own_valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      own_id_q    <= '0;
      own_valid_q <= 1'b0;
      ptr_q       <= MID_W'(NUM_MST-1);
      data_sel_q  <= '0;
    end else begin
      own_id_q    <= own_id_d;
      own_valid_q <= own_valid_d;
      ptr_q       <= ptr_d;
      data_sel_q  <= data_sel_d;
    end
  end

  assign data_sel   = data_sel_q;
  assign addr_valid = own_valid_q;
  assign no_port    = ~own_valid_q;
  assign HMASTER    = own_id_q;
  assign HMASTLOCKM = own_valid_q & mastlock[own_id_q];

endmodule

// File: tb/tb_l2_ahb_output_arb.sv
// tb/tb_l2_ahb_output_arb.sv - directed bench with ownership model for l2_ahb_output_arb
module tb_l2_ahb_output_arb;

  localparam int N = 3;

  logic       HCLK = 1'b0;
  logic       HRESET = 1'b1;
  logic [2:0] req_in = '0;
  logic [2:0] held_tran = '0;
  logic [2:0] mastlock = '0;
  logic       HREADYM = 1'b1;
  logic [2:0] addr_sel, data_sel;
  logic       addr_valid, no_port, HMASTLOCKM;
  logic [1:0] HMASTER;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model: owner index (-1 = none), last winner, data-phase owner, last reported master.
  int m_owner = -1;
  int m_last  = N-1;
  int m_data  = -1;
  int m_hm    = 0;

  l2_ahb_output_arb #(.NUM_MST(3), .MID_W(2)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .req_in(req_in), .held_tran(held_tran),
    .mastlock(mastlock), .HREADYM(HREADYM), .addr_sel(addr_sel), .data_sel(data_sel),
    .addr_valid(addr_valid), .no_port(no_port), .HMASTER(HMASTER), .HMASTLOCKM(HMASTLOCKM)
  );

  always #5 HCLK = ~HCLK;

  function automatic int pick(int last, logic [2:0] r);
    int j;
    for (int i = 1; i <= N; i++) begin
      j = (last + i) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [2:0] onehot(int idx);
    logic [2:0] v;
    v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge HCLK) begin
    if (HRESET) begin
      m_owner <= -1;
      m_last  <= N-1;
      m_data  <= -1;
      m_hm    <= 0;
    end else if (HREADYM) begin
      m_data <= m_owner;
      if (!(m_owner >= 0 && (held_tran[m_owner] || mastlock[m_owner]))) begin
        if (pick(m_last, req_in) >= 0) begin
          m_owner <= pick(m_last, req_in);
          m_last  <= pick(m_last, req_in);
          m_hm    <= pick(m_last, req_in);
        end else begin
          m_owner <= -1;
        end
      end
    end
  end

  always @(negedge HCLK) begin
    if (chk_en) begin
      chk("m_addr_sel", 8'(addr_sel), 8'(onehot(m_owner)));
      chk("m_data_sel", 8'(data_sel), 8'(onehot(m_data)));
      chk("m_addr_valid", 8'(addr_valid), 8'(m_owner >= 0));
      chk("m_no_port", 8'(no_port), 8'(m_owner < 0));
      chk("m_hmaster", 8'(HMASTER), 8'(m_hm));
      chk("m_lock", 8'(HMASTLOCKM), 8'((m_owner >= 0) ? mastlock[m_owner] : 1'b0));
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_addr", 8'(addr_sel), 8'h0);
    chk("rst_data", 8'(data_sel), 8'h0);
    chk("rst_noport", 8'(no_port), 8'h1);
    chk("rst_hmaster", 8'(HMASTER), 8'h0);
    chk("rst_lock", 8'(HMASTLOCKM), 8'h0);
    chk_en = 1'b1;

    // all requesting: strict rotation 0,1,2,0,1,2 with data_sel one cycle behind
    HRESET = 1'b0;
    req_in = 3'b111;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_addr", 8'(addr_sel), 8'(3'b001 << (i % 3)));
      chk("rr_hmaster", 8'(HMASTER), 8'(i % 3));
      chk("rr_data", 8'(data_sel), (i == 0) ? 8'h0 : 8'(3'b001 << ((i - 1) % 3)));
    end

    // burst continuation holds master 1
    tick();
    tick();
    chk("burst_own", 8'(addr_sel), 8'h2);
    held_tran = 3'b010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("burst_hold", 8'(addr_sel), 8'h2);
    end
    held_tran = 3'b000;
    tick();
    chk("burst_next", 8'(addr_sel), 8'h4);

    // locked sequence with an idle inside it
    tick();
    chk("lock_own", 8'(addr_sel), 8'h1);
    mastlock = 3'b001;
    req_in   = 3'b100;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("lock_hold", 8'(addr_sel), 8'h1);
      chk("lock_out", 8'(HMASTLOCKM), 8'h1);
    end
    mastlock = 3'b000;
    tick();
    chk("lock_next", 8'(addr_sel), 8'h4);

    // wait states freeze everything
    HREADYM = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_in = 3'(i + 1);
      tick();
      chk("frz_addr", 8'(addr_sel), 8'h4);
      chk("frz_data", 8'(data_sel), 8'h1);
      chk("frz_hm", 8'(HMASTER), 8'h2);
    end
    HREADYM = 1'b1;
    req_in  = 3'b010;
    tick();
    chk("unfrz_data", 8'(data_sel), 8'h4);
    chk("unfrz_addr", 8'(addr_sel), 8'h2);

    // lone requester keeps the port back to back, then the port idles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lone_addr", 8'(addr_sel), 8'h2);
    end
    req_in = 3'b000;
    tick();
    chk("idle_addr", 8'(addr_sel), 8'h0);
    chk("idle_noport", 8'(no_port), 8'h1);
    chk("idle_hm", 8'(HMASTER), 8'h1);
    req_in = 3'b001;
    tick();
    chk("after_idle", 8'(addr_sel), 8'h1);
    req_in = 3'b111;
    tick();
    chk("after_idle_rr", 8'(addr_sel), 8'h2);

    // reset in the middle of a stalled locked burst
    req_in    = 3'b010;
    mastlock  = 3'b010;
    held_tran = 3'b010;
    HREADYM   = 1'b0;
    tick();
    chk("pre_rst_lock", 8'(HMASTLOCKM), 8'h1);
    HRESET = 1'b1;
    tick();
    chk("mrst_addr", 8'(addr_sel), 8'h0);
    chk("mrst_data", 8'(data_sel), 8'h0);
    chk("mrst_hm", 8'(HMASTER), 8'h0);
    chk("mrst_lock", 8'(HMASTLOCKM), 8'h0);
    HRESET    = 1'b0;
    mastlock  = 3'b000;
    held_tran = 3'b000;
    HREADYM   = 1'b1;
    req_in    = 3'b111;
    tick();
    chk("post_rst_grant", 8'(addr_sel), 8'h1);
    tick();
    tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_ahb_output_arb.md
Name: l2_ahb_output_arb

Overview:
Round-robin arbiter for one slave-side output port of the L2 AHB bus matrix, shared between NUM_MST master input stages. It decides which master owns the slave's address phase and tracks which master owns the data phase. Bursts and locked sequences are never broken. Address-phase ownership is the owner's registered grant; data-phase ownership follows it when HREADYM is high. The matrix output-stage muxes use addr_sel and data_sel.

Parameters:
NUM_MST, 3, number of master input stages sharing this port (2..8)
MID_W, 2, width of HMASTER; must be >= ceil(log2(NUM_MST))

Ports:
HCLK  in  1  bus clock; all state changes on rising edge
HRESET  in  1  synchronous, active-high reset
req_in  in  NUM_MST  bit i: master i has a pending transfer to this port (its HSEL & HTRANS[1], held by its input stage until granted)
held_tran  in  NUM_MST  bit i: master i's current address phase is SEQ or BUSY (burst continuation)
mastlock  in  NUM_MST  bit i: HMASTLOCK from master i
HREADYM  in  1  slave-port HREADY; high = current data phase completes this cycle
addr_sel  out  NUM_MST  one-hot address-phase owner, or all zero
data_sel  out  NUM_MST  one-hot data-phase owner, or all zero
addr_valid  out  1  high when addr_sel is non-zero
no_port  out  1  inverse of addr_valid; output stage drives HTRANS=IDLE
HMASTER  out  MID_W  index of the current or most recent address-phase owner
HMASTLOCKM  out  1  addr_valid & mastlock[owner]; combinational from registered state

Behaviour:
- State registers:
  - own_id [MID_W]: owner index
  - own_valid: owner present
  - ptr [MID_W]: round-robin pointer, the last winner
  - data_sel
- addr_sel is the one-hot decode of own_id, gated by own_valid. addr_valid = own_valid. HMASTER = own_id.
- Reset values (one HCLK edge with HRESET=1):
  - own_valid=0, own_id=0, ptr=NUM_MST-1
  - data_sel=0, so addr_sel=0, addr_valid=0, no_port=1, HMASTER=0, HMASTLOCKM=0
  - Master 0 has first priority after reset.
- Reset dominates HREADYM and all requests. Reset asserted mid-burst or mid-lock clears ownership immediately; there is no completion of the pending data phase.
- Freeze: when HREADYM=0, every register holds its value, whatever req_in, held_tran or mastlock do. This covers wait states and the two-cycle ERROR response.
- Hold condition: hold = own_valid & (held_tran[own_id] | mastlock[own_id]). When HREADYM=1 and hold=1, ownership is unchanged, even if req_in[own_id]=0. This covers an IDLE inside a locked sequence.
- Arbitration: when HREADYM=1 and hold=0:
  - Search req_in starting at index (ptr+1) mod NUM_MST and wrapping. The first set bit wins.
  - On a winner: own_id<=winner, own_valid<=1, ptr<=winner.
  - With no request: own_valid<=0, and own_id and ptr keep their values.
  - The previous owner has the lowest priority. If it is the only requester, it keeps the port with no idle cycle between grants.
- Grant latency: a request sampled with HREADYM=1 at edge n gives addr_sel on the cycle after edge n. The input stage presents the held transfer in that cycle.
- Data phase: when HREADYM=1, data_sel <= addr_sel (all zero if no owner). Otherwise data_sel holds.
- Outputs:
  - addr_sel and data_sel are at most one-hot.
  - No index >= NUM_MST is ever produced. Wrap uses a compare, not bit truncation, so non-power-of-2 NUM_MST works.
- Simultaneous events: a new request and a hold on the same edge means the hold wins, and the request stays pending. All masters requesting rotate strictly one grant each: 0,1,2,0,…
- mastlock from a non-owner is ignored until that master is granted.

Test Plan:
1. Reset, then req_in=3'b111 and HREADYM=1 held constant for 6 cycles -> addr_sel=001,010,100,001,010,100; data_sel lags by one cycle; HMASTER=0,1,2,0,1,2.
2. Master 1 owns the port with held_tran[1]=1 for 3 cycles and req_in=3'b111 -> addr_sel stays 010 for those 3 cycles. After held_tran[1] drops, the next owner is master 2 (100).
3. Master 0 granted with mastlock[0]=1, then req_in[0]=0 for 2 cycles while req_in[2]=1 -> addr_sel stays 001 and HMASTLOCKM=1. After mastlock drops, master 2 is granted.
4. Master 2 owns the port, HREADYM=0 for 4 cycles while req_in changes -> addr_sel, data_sel and HMASTER are frozen. On the first HREADYM=1 edge, arbitration resumes and data_sel becomes 100.
5. Only master 1 requests, then req_in=0 -> addr_sel 010 continuously with no gap, then 000 with no_port=1 and HMASTER=1. A new request from master 0 is then granted, with ptr advanced from 1.
6. HRESET pulsed for one cycle while master 1 holds a locked burst with HREADYM=0 -> next cycle addr_sel=000, data_sel=000, HMASTER=0, HMASTLOCKM=0. The next grant with req_in=3'b111 goes to master 0.
